// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler: op codes,
// FSM state type, default latencies and the divide-by-zero quotient value.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned MD_MULT_CYCLES_DEF = 32'd5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 32'd10;

  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // True for the four ops that use the multi-cycle countdown.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op <= MD_DIVU);
  endfunction

  // True for DIV/DIVU.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// Handshake/data bundle between the E/D pipeline stages and the MD scheduler.
// master = pipeline side, slave = scheduler side.
interface md_scheduler_if;
  logic        start;
  logic [2:0]  op;
  logic        cancel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  modport master (
    output start, op, cancel, rs_val, rt_val, md_use_d,
    input  busy, stall_md, hi, lo, done
  );

  modport slave (
    input  start, op, cancel, rs_val, rt_val, md_use_d,
    output busy, stall_md, hi, lo, done
  );
endinterface

// File: rtl/md_arith.sv
// Combinational HI/LO result for MULT/MULTU/DIV/DIVU.
// result_o = {hi, lo}. Divide by zero gives lo = all ones, hi = dividend;
// signed 0x80000000 / -1 gives lo = 0x80000000, hi = 0.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [63:0] result_o
);

  logic               div_zero_s;
  logic               div_ovf_s;
  logic [31:0]        safe_rt_s;
  logic signed [63:0] mul_s_s;
  logic [63:0]        mul_u_s;
  logic signed [31:0] quo_s_s;
  logic signed [31:0] rem_s_s;
  logic [31:0]        quo_u_s;
  logic [31:0]        rem_u_s;

  assign div_zero_s = (rt_val_i == 32'd0);
  assign div_ovf_s  = (op_i == MD_DIV) && (rs_val_i == 32'h8000_0000) &&
                      (rt_val_i == 32'hFFFF_FFFF);
  // Divisor of 1 in the special cases keeps the dividers well-defined;
  // for the overflow case it also yields exactly the required result.
  assign safe_rt_s  = (div_zero_s || div_ovf_s) ? 32'd1 : rt_val_i;

  assign mul_s_s = $signed({{32{rs_val_i[31]}}, rs_val_i}) *
                   $signed({{32{rt_val_i[31]}}, rt_val_i});
  assign mul_u_s = {32'd0, rs_val_i} * {32'd0, rt_val_i};
  assign quo_s_s = $signed(rs_val_i) / $signed(safe_rt_s);
  assign rem_s_s = $signed(rs_val_i) % $signed(safe_rt_s);
  assign quo_u_s = rs_val_i / safe_rt_s;
  assign rem_u_s = rs_val_i % safe_rt_s;

  // Select the result for the requested op, applying the divide-by-zero rule.
  always_comb begin
    result_o = 64'd0;
    case (op_i)
      MD_MULT:  result_o = mul_s_s;
      MD_MULTU: result_o = mul_u_s;
      MD_DIV: begin
        if (div_zero_s) result_o = {rs_val_i, DIV_ZERO_LO};
        else            result_o = {rem_s_s, quo_s_s};
      end
      MD_DIVU: begin
        if (div_zero_s) result_o = {rs_val_i, DIV_ZERO_LO};
        else            result_o = {rem_u_s, quo_u_s};
      end
      default: result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Multi-cycle HI/LO multiply/divide scheduler.
// Runs the fixed-latency countdown, owns HI/LO, raises the D-stage stall.
// Optional: define MD_EARLY_ZERO_EN to finish trivially-zero ops in one cycle.
module md_scheduler
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input logic          clk,
  input logic          reset,
  md_scheduler_if.slave md
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 32'd1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 32'd1);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        eff_s;
  logic        early_zero_s;
  logic [63:0] arith_res_s;

  md_arith u_arith (
    .op_i     (md.op),
    .rs_val_i (md.rs_val),
    .rt_val_i (md.rt_val),
    .result_o (arith_res_s)
  );

  assign eff_s = md.start & ~md.cancel & (state_q == IDLE);

`ifdef MD_EARLY_ZERO_EN
  assign early_zero_s =
      (!is_div_op(md.op) && ((md.rs_val == 32'd0) || (md.rt_val == 32'd0))) ||
      ( is_div_op(md.op) &&  (md.rs_val == 32'd0) && (md.rt_val != 32'd0));
`else
  assign early_zero_s = 1'b0;
`endif

  // Next-state, countdown, pending-result and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (eff_s) begin
          case (md.op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              if (early_zero_s) begin
                hi_d   = arith_res_s[63:32];
                lo_d   = arith_res_s[31:0];
                done_d = 1'b1;
              end else begin
                state_d   = RUN;
                cnt_d     = is_div_op(md.op) ? DIV_LOAD : MULT_LOAD;
                pend_hi_d = arith_res_s[63:32];
                pend_lo_d = arith_res_s[31:0];
              end
            end
            MD_MTHI: hi_d = md.rs_val;
            MD_MTLO: lo_d = md.rs_val;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // start/cancel are deliberately ignored here: a running op always commits.
        if (cnt_q == 4'd0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers with synchronous reset (aborts any countdown).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign md.busy     = (state_q == RUN);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.done     = done_q;
  // Stall must cover the issue cycle too, so it looks at this cycle's start.
  assign md.stall_md = md.md_use_d &
                       ((state_q == RUN) | (md.start & ~md.cancel & is_md_op(md.op)));

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed spec scenarios plus random
// ops checked against an arithmetic reference model of HI/LO and timing.
module tb_md_scheduler;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  md_scheduler_if md_if();

  md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  // A start accepted while the unit is running should never be issued.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(md_if.start && !md_if.cancel && md_if.busy))
        else $error("illegal start while busy");
    end
  end

  // Reference {hi, lo} computed with 64-bit integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] rs,
                                         input logic [31:0] rt);
    longint a, b, q, r, p;
    logic [63:0] res;
    res = 64'd0;
    if (op == 3'd0 || op == 3'd2) begin
      a = longint'($signed(rs));
      b = longint'($signed(rt));
    end else begin
      a = longint'({32'd0, rs});
      b = longint'({32'd0, rt});
    end
    if (op <= 3'd1) begin
      p = a * b;
      res = p;
    end else if (op <= 3'd3) begin
      if (rt == 32'd0) begin
        res = {rs, 32'hFFFF_FFFF};
      end else begin
        q = a / b;
        r = a % b;
        res = {r[31:0], q[31:0]};
      end
    end
    return res;
  endfunction

  function automatic bit early_zero(input logic [2:0] op, input logic [31:0] rs,
                                    input logic [31:0] rt);
`ifdef MD_EARLY_ZERO_EN
    if (op <= 3'd1) return (rs == 32'd0) || (rt == 32'd0);
    if (op <= 3'd3) return (rs == 32'd0) && (rt != 32'd0);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int busy_len(input logic [2:0] op, input logic [31:0] rs,
                                  input logic [31:0] rt);
    if (op > 3'd3 || early_zero(op, rs, rt)) return 0;
    return (op <= 3'd1) ? MULT_N : DIV_N;
  endfunction

  // Apply the architectural effect of an accepted op to the model.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] r;
    r = ref_md(op, rs, rt);
    if (op <= 3'd3) begin
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end else if (op == 3'd4) begin
      exp_hi = rs;
    end else if (op == 3'd5) begin
      exp_lo = rs;
    end
  endtask

  // Drive one start cycle (caller is away from the clock edge), check stall.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic use_d, input logic cnl);
    logic exp_stall;
    md_if.start = 1'b1; md_if.op = op; md_if.rs_val = rs; md_if.rt_val = rt;
    md_if.cancel = cnl; md_if.md_use_d = use_d;
    #1;
    exp_stall = use_d & ~cnl & (op <= 3'd3);
    checks++;
    if (md_if.stall_md !== exp_stall) begin
      errors++;
      $display("FAIL issue_stall op=%0d got %b expected %b", op, md_if.stall_md, exp_stall);
    end
    @(posedge clk); #1;
    md_if.start = 1'b0; md_if.cancel = 1'b0;
  endtask

  // Count busy cycles, then check done pulse and committed HI/LO.
  task automatic finish_op(input string nm, input int exp_n, input logic use_d,
                           input logic exp_done);
    int n;
    bit timeout;
    n = 0; timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!md_if.busy) begin timeout = 1'b0; break; end
      n++;
      checks++;
      if (md_if.stall_md !== use_d || md_if.done !== 1'b0) begin
        errors++;
        $display("FAIL %s_run_stall got stall=%b done=%b expected stall=%b done=0",
                 nm, md_if.stall_md, md_if.done, use_d);
      end
    end
    checks++;
    if (timeout || n != exp_n) begin
      errors++;
      $display("FAIL %s_busy_len got %0d expected %0d (timeout=%0d)", nm, n, exp_n, timeout);
    end
    checks++;
    if (md_if.done !== exp_done) begin
      errors++;
      $display("FAIL %s_done got %b expected %b", nm, md_if.done, exp_done);
    end
    checks++;
    if (md_if.hi !== exp_hi || md_if.lo !== exp_lo) begin
      errors++;
      $display("FAIL %s_hilo got %h_%h expected %h_%h", nm, md_if.hi, md_if.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic check_done_low(input string nm);
    @(negedge clk);
    checks++;
    if (md_if.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse got %b expected 0", nm, md_if.done);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic use_d);
    int n;
    @(posedge clk); #1;
    n = busy_len(op, rs, rt);
    issue(op, rs, rt, use_d, 1'b0);
    model_apply(op, rs, rt);
    finish_op(nm, n, use_d, op <= 3'd3);
    check_done_low(nm);
  endtask

  task automatic check_const(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
    checks++;
    if (md_if.hi !== ehi || md_if.lo !== elo) begin
      errors++;
      $display("FAIL %s got hi=%h lo=%h expected hi=%h lo=%h", nm, md_if.hi, md_if.lo, ehi, elo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    md_if.start = 1'b0; md_if.op = 3'd0; md_if.cancel = 1'b0;
    md_if.rs_val = 32'd0; md_if.rt_val = 32'd0; md_if.md_use_d = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (md_if.busy !== 1'b0 || md_if.done !== 1'b0 || md_if.stall_md !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b stall=%b expected 0 0 0",
               md_if.busy, md_if.done, md_if.stall_md);
    end
    check_const("reset_hilo", 32'd0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_arith_directed();
    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check_const("mult_const", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check_const("multu_const", 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check_const("div_const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 3'd3, 32'h0000_1234, 32'd0, 1'b1);
    check_const("divu_zero_const", 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_zero", 3'd2, 32'h8765_4321, 32'd0, 1'b0);
    check_const("div_zero_const", 32'h8765_4321, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check_const("div_ovf_const", 32'h0000_0000, 32'h8000_0000);
    run_op("mult_zero", 3'd0, 32'h0000_1234, 32'd0, 1'b1);
    check_const("mult_zero_const", 32'd0, 32'd0);
  endtask

  task automatic test_mtlo_mthi();
    run_op("mtlo", 3'd5, 32'h0000_ABCD, 32'h5555_5555, 1'b1);
    check_const("mtlo_const", exp_hi, 32'h0000_ABCD);
    run_op("mthi", 3'd4, 32'h1357_9BDF, 32'd0, 1'b0);
    run_op("nop6", 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b1);
    run_op("nop7", 3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0);
  endtask

  task automatic test_cancel();
    @(posedge clk); #1;
    issue(3'd0, 32'd3, 32'd4, 1'b1, 1'b1);
    finish_op("cancel", 0, 1'b1, 1'b0);
    check_done_low("cancel");
  endtask

  task automatic test_cancel_in_run();
    @(posedge clk); #1;
    issue(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    model_apply(3'd3, 32'd100, 32'd7);
    md_if.cancel = 1'b1;
    finish_op("cancel_run", DIV_N, 1'b0, 1'b1);
    md_if.cancel = 1'b0;
    check_const("cancel_run_const", 32'd2, 32'd14);
    check_done_low("cancel_run");
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
    model_apply(3'd0, 32'd7, 32'hFFFF_FFFD);
    finish_op("b2b_first", MULT_N, 1'b1, 1'b1);
    // Issue the next op in the very cycle busy drops.
    issue(3'd2, 32'd1000, 32'hFFFF_FFFD, 1'b1, 1'b0);
    model_apply(3'd2, 32'd1000, 32'hFFFF_FFFD);
    finish_op("b2b_second", DIV_N, 1'b1, 1'b1);
    check_done_low("b2b");
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    @(posedge clk); #1;
    issue(3'd2, 32'd12345, 32'd17, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    checks++;
    if (md_if.busy !== 1'b0 || md_if.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ctrl got busy=%b done=%b expected 0 0", md_if.busy, md_if.done);
    end
    check_const("reset_mid_hilo", 32'd0, 32'd0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (md_if.done !== 1'b0 || md_if.busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_mid_late got late done/busy activity expected none");
    end
    check_const("reset_mid_hold", 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        use_d;
    for (int i = 0; i < 40; i++) begin
      op    = 3'($urandom_range(0, 7));
      rs    = pick_operand();
      rt    = pick_operand();
      use_d = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), op, rs, rt, use_d);
    end
  endtask

  initial begin
    test_reset();
    test_arith_directed();
    test_mtlo_mthi();
    test_cancel();
    test_cancel_in_run();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Multi-cycle controller for the HI/LO multiply/divide resource in the 5-stage pipeline.
- Accepts MD operations issued from E stage and runs the fixed-latency countdown for MULT/MULTU/DIV/DIVU.
- Owns the HI/LO registers and commits results when the countdown ends.
- Generates the D-stage stall for MD-using instructions and honours the pipeline cancel (flush/interrupt) so a killed instruction never starts.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  E stage holds a valid MD instruction this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored
- cancel  in  1  E-stage instruction is being flushed; suppresses start this cycle
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / MT source)
- rt_val  in  32  forwarded rt operand
- md_use_d  in  1  D-stage instruction is MULT/DIV/MFHI/MFLO/MTHI/MTLO
- busy  out  1  countdown in progress
- stall_md  out  1  stall request to the F/D and D/E registers
- hi  out  32  HI register
- lo  out  32  LO register
- done  out  1  one-cycle pulse the cycle after HI/LO commit

Behaviour:
- Clock and reset: reset is synchronous and active-high; clock is clk.
- Reset values: state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, pending results=0.
- Reset mid-operation aborts the countdown; no commit occurs.
- Effective start: eff = start & ~cancel & (state==IDLE).
- States:
  - IDLE: on eff with op 0–3, go to RUN at the same edge E0.
    - Load cnt = N-1 (N = MULT_CYCLES or DIV_CYCLES).
    - Compute the result from rs_val/rt_val and latch it into pend_hi/pend_lo.
  - RUN: each edge with cnt!=0 decrements cnt. The edge with cnt==0 (EN) writes hi/lo from pending, enters IDLE, and sets done=1 for one cycle.
- Timing: busy = (state==RUN), high for exactly N cycles. A new MD op can issue in the cycle busy falls.
- MTHI/MTLO (op 4/5) with eff: write hi (or lo) = rs_val at the next edge. No busy, no done.
- Arithmetic:
  - MULT: signed 32x32→64; hi = upper 32 bits, lo = lower 32 bits.
  - MULTU: unsigned 32x32→64; same split.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned; same hi/lo assignment.
  - 0x80000000 / -1: lo = 0x80000000, hi = 0.
  - Divisor 0: lo = 0xFFFFFFFF, hi = rs_val. Applies to signed and unsigned.
- stall_md = md_use_d & (busy | (start & ~cancel & op<=3)).
- start while in RUN is illegal, since stall_md prevents it. If it occurs it is ignored and the RUN state is unaffected; the bench flags it with an assertion.
- cancel has no effect on an operation already in RUN; it completes and commits.
- Op codes 6–7 are no-ops.

Optional Feature:
- Macro: MD_EARLY_ZERO_EN.
- Defined: a MULT/MULTU with rs_val==0 or rt_val==0, or a DIV/DIVU with rs_val==0 and rt_val!=0:
  - is a single-cycle op: hi/lo written at E0, done pulses next cycle, busy never rises;
  - stall_md still follows the formula above for the issue cycle.
- Undefined: all MD ops take the full N cycles.

Decomposition:
- Package md_pkg holds:
  - op code constants MD_MULT..MD_MTLO;
  - state enum {IDLE, RUN};
  - default latencies;
  - DIV_ZERO_LO constant 0xFFFFFFFF.
- Sub-module md_arith: purely combinational 64-bit result from (op, rs_val, rt_val), including the divide-by-zero and overflow rules.
- md_scheduler contains the FSM, counter, HI/LO registers and stall logic.

Test Plan:
- Reset, then MULT with rs=0xFFFFFFFF (-1), rt=2 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses 1 cycle.
- MULTU with rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- DIV with rs=-7 (0xFFFFFFF9), rt=2, with md_use_d=1 throughout:
  - stall_md high in the issue cycle plus all 10 busy cycles;
  - result lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with rt=0, rs=0x1234 → lo=0xFFFFFFFF, hi=0x1234.
- start=1, op=MULT, cancel=1 → busy stays 0, hi/lo unchanged.
- MTLO with rs=0xABCD in the same cycle as cancel=0 → lo=0xABCD next cycle, busy=0.
- DIV in flight, reset asserted at busy cycle 4 → next cycle busy=0, hi=lo=0, no done pulse.
- With MD_EARLY_ZERO_EN: MULT with rt=0 → busy never rises, hi=lo=0 after 1 edge, done pulses.
